// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared opcodes, FSM encoding and datapath default width.
package alu_sequencer_pkg;
  localparam int WIDTH_DEF = 16;
  localparam logic [2:0] OP_ZERO     = 3'd0;
  localparam logic [2:0] OP_ADD      = 3'd1;
  localparam logic [2:0] OP_SUB      = 3'd2;
  localparam logic [2:0] OP_AND      = 3'd3;
  localparam logic [2:0] OP_OR       = 3'd4;
  localparam logic [2:0] OP_XOR      = 3'd5;
  localparam logic [2:0] OP_PASS_LHS = 3'd6;
  localparam logic [2:0] OP_PASS_RHS = 3'd7;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/alu_sequencer_regfile.sv
// alu_sequencer_regfile: NREGS x WIDTH register file, two async operand reads, debug read, one sync write.
module alu_sequencer_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  parameter int RAW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [RAW-1:0]   i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [RAW-1:0]   i_raddr_a,
  input  logic [RAW-1:0]   i_raddr_b,
  input  logic [RAW-1:0]   i_dbg_sel,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b,
  output logic [WIDTH-1:0] o_dbg_data
);
  logic [WIDTH-1:0] r_mem [NREGS];
  always_ff @(posedge clk) begin
    if (rst) r_mem <= '{default: '0};
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_sel];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts reg/imm ALU commands, drives the external ALU, writes back and returns the result.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = 4,
  parameter int RAW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [RAW-1:0]   cmd_src_a,
  input  logic [RAW-1:0]   cmd_src_b,
  input  logic             cmd_use_imm,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [RAW-1:0]   cmd_dst,
  input  logic             cmd_wb,
  output logic [2:0]       alu_operation,
  output logic [WIDTH-1:0] alu_op_lhs,
  output logic [WIDTH-1:0] alu_op_rhs,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  input  logic [RAW-1:0]   dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);
  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [RAW-1:0]   r_src_a, r_src_b, r_dst;
  logic             r_use_imm, r_wb;
  logic [WIDTH-1:0] r_imm;
  logic             r_rsp_valid, r_rsp_zero;
  logic [WIDTH-1:0] r_rsp_data;
  logic [WIDTH-1:0] w_rd_a, w_rd_b;
  logic             w_we;
  assign w_we = (r_state == ST_EXEC) && r_wb;
  alu_sequencer_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .RAW(RAW)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_we),
    .i_waddr    (r_dst),
    .i_wdata    (alu_result),
    .i_raddr_a  (r_src_a),
    .i_raddr_b  (r_src_b),
    .i_dbg_sel  (dbg_sel),
    .o_rdata_a  (w_rd_a),
    .o_rdata_b  (w_rd_b),
    .o_dbg_data (dbg_data)
  );
  // Operands come straight from the regfile, so a writeback is visible to the next EXEC.
  assign alu_operation = r_op;
  assign alu_op_lhs    = w_rd_a;
  assign alu_op_rhs    = r_use_imm ? r_imm : w_rd_b;
  assign cmd_ready     = (r_state == ST_IDLE);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign rsp_zero      = r_rsp_zero;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_src_a     <= '0;
      r_src_b     <= '0;
      r_use_imm   <= 1'b0;
      r_imm       <= '0;
      r_dst       <= '0;
      r_wb        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && cmd_valid) begin
        r_op      <= cmd_op;
        r_src_a   <= cmd_src_a;
        r_src_b   <= cmd_src_b;
        r_use_imm <= cmd_use_imm;
        r_imm     <= cmd_imm;
        r_dst     <= cmd_dst;
        r_wb      <= cmd_wb;
        r_state   <= ST_EXEC;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_data  <= alu_result;
        r_rsp_zero  <= (alu_result == '0);
        r_rsp_valid <= 1'b1;
        r_state     <= ST_RESP;
      end
      if (r_state == ST_RESP && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_state     <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed scoreboard bench with a behavioural ALU and register model.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [1:0]  cmd_src_a = '0, cmd_src_b = '0, cmd_dst = '0, dbg_sel = '0;
  logic        cmd_use_imm = 1'b0, cmd_wb = 1'b0;
  logic [15:0] cmd_imm = '0;
  logic [2:0]  alu_operation;
  logic [15:0] alu_op_lhs, alu_op_rhs, alu_result, rsp_data, dbg_data;
  logic        rsp_valid, rsp_zero;
  logic        rsp_ready = 1'b0;
  int tests = 0, fails = 0, cyc = 0, rsp_cyc = 0, t0 = 0;
  logic [15:0] m_reg [4];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return a;
      3'd7: return b;
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_result = alu_f(alu_operation, alu_op_lhs, alu_op_rhs);

  alu_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_use_imm(cmd_use_imm),
    .cmd_imm(cmd_imm), .cmd_dst(cmd_dst), .cmd_wb(cmd_wb),
    .alu_operation(alu_operation), .alu_op_lhs(alu_op_lhs), .alu_op_rhs(alu_op_rhs),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic dbg(input logic [1:0] idx, input logic [15:0] exp);
    dbg_sel = idx;
    #1;
    check($sformatf("dbg_r%0d", idx), {16'h0, dbg_data}, {16'h0, exp});
  endtask

  task automatic cmd(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                     input logic ui, input logic [15:0] imm, input logic [1:0] dst,
                     input logic wb, input logic push);
    logic [15:0] res;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    check("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
    cmd_op = op; cmd_src_a = a; cmd_src_b = b; cmd_use_imm = ui;
    cmd_imm = imm; cmd_dst = dst; cmd_wb = wb; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (push) begin
      res = alu_f(op, m_reg[a], ui ? imm : m_reg[b]);
      if (wb) m_reg[dst] = res;
      exp_q.push_back(res);
    end
  endtask

  task automatic get_rsp(input string tag);
    logic [15:0] e;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    check({tag, "_valid"}, {31'h0, rsp_valid}, 32'h1);
    rsp_cyc = cyc;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    check({tag, "_data"}, {16'h0, rsp_data}, {16'h0, e});
    check({tag, "_zero"}, {31'h0, rsp_zero}, {31'h0, e == 16'h0});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    m_reg = '{default: 16'h0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_data", {16'h0, rsp_data}, 32'h0);
    check("rst_rsp_zero", {31'h0, rsp_zero}, 32'h0);
    check("rst_alu_op", {29'h0, alu_operation}, 32'h0);
    check("rst_alu_lhs", {16'h0, alu_op_lhs}, 32'h0);
    check("rst_alu_rhs", {16'h0, alu_op_rhs}, 32'h0);
    for (int i = 0; i < 4; i++) dbg(i[1:0], 16'h0);
    // Load immediates
    cmd(3'd7, 0, 0, 1, 16'h1234, 0, 1, 1); get_rsp("ld0");
    cmd(3'd7, 0, 0, 1, 16'h0FFF, 1, 1, 1); get_rsp("ld1");
    dbg(0, 16'h1234); dbg(1, 16'h0FFF);
    // Add/sub wrap
    cmd(3'd7, 0, 0, 1, 16'hFFFF, 0, 1, 1); get_rsp("ld_ffff");
    cmd(3'd7, 0, 0, 1, 16'h0002, 1, 1, 1); get_rsp("ld_2");
    cmd(3'd1, 0, 1, 0, 16'h0, 2, 1, 1); get_rsp("add_wrap");
    dbg(2, 16'h0001);
    cmd(3'd2, 1, 0, 0, 16'h0, 3, 0, 1); get_rsp("sub_wrap");
    dbg(3, 16'h0000);
    // Logic ops and zero flag
    cmd(3'd7, 0, 0, 1, 16'hF0F0, 0, 1, 1); get_rsp("ld_f0f0");
    cmd(3'd7, 0, 0, 1, 16'h5555, 3, 1, 1); get_rsp("ld_r3");
    cmd(3'd5, 0, 0, 1, 16'hF0F0, 3, 1, 1); get_rsp("xor_zero");
    dbg(3, 16'h0000);
    cmd(3'd3, 0, 2, 0, 16'h0, 1, 1, 1); get_rsp("and");
    cmd(3'd4, 0, 2, 0, 16'h0, 1, 0, 1); get_rsp("or");
    cmd(3'd6, 2, 0, 1, 16'hAAAA, 1, 0, 1); get_rsp("pass_lhs");
    cmd(3'd0, 0, 1, 0, 16'h0, 1, 0, 1); get_rsp("op_zero");
    // Backpressure with an ignored command pulse
    cmd(3'd7, 0, 0, 1, 16'hABCD, 1, 0, 1);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp_data", {16'h0, rsp_data}, 32'hABCD);
      check("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      cmd_valid = (i == 2); cmd_op = 3'd7; cmd_use_imm = 1'b1;
      cmd_imm = 16'h7777; cmd_dst = 2'd3; cmd_wb = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    get_rsp("bp");
    check("bp_idle_ready", {31'h0, cmd_ready}, 32'h1);
    @(negedge clk);
    check("bp_no_extra_rsp", {31'h0, rsp_valid}, 32'h0);
    dbg(3, m_reg[3]);
    // Dependent back-to-back
    cmd(3'd7, 0, 0, 1, 16'h0005, 0, 1, 1); get_rsp("ld5");
    cmd(3'd1, 0, 0, 1, 16'h0001, 0, 1, 1); get_rsp("dep1");
    check("dep1_val", {16'h0, m_reg[0]}, 32'h6);
    t0 = rsp_cyc;
    cmd(3'd1, 0, 0, 1, 16'h0001, 0, 1, 1); get_rsp("dep2");
    check("dep2_spacing", rsp_cyc - t0, 32'd3);
    t0 = rsp_cyc;
    cmd(3'd1, 0, 0, 1, 16'h0001, 0, 1, 1); get_rsp("dep3");
    check("dep3_spacing", rsp_cyc - t0, 32'd3);
    dbg(0, 16'h0008);
    cmd(3'd1, 0, 0, 1, 16'h0001, 0, 0, 1); get_rsp("nowb");
    dbg(0, 16'h0008);
    // Reset during EXEC
    cmd(3'd7, 0, 0, 1, 16'h00EE, 2, 1, 1); get_rsp("ld_r2");
    cmd(3'd1, 0, 1, 0, 16'h0, 2, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reg = '{default: 16'h0};
    check("rx_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("rx_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rx_rsp_data", {16'h0, rsp_data}, 32'h0);
    check("rx_alu_op", {29'h0, alu_operation}, 32'h0);
    check("rx_alu_lhs", {16'h0, alu_op_lhs}, 32'h0);
    check("rx_alu_rhs", {16'h0, alu_op_rhs}, 32'h0);
    dbg(2, 16'h0000); dbg(0, 16'h0000);
    repeat (3) @(negedge clk);
    check("rx_still_no_rsp", {31'h0, rsp_valid}, 32'h0);
    cmd(3'd7, 0, 0, 1, 16'h0007, 2, 1, 1); get_rsp("post_rst");
    dbg(2, 16'h0007);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
